// File: rtl/serial_slave_port.sv
// Serial slave port: receives an LSB-first address (and write data) over a
// single-bit bus, issues one memory strobe, and returns read data serially.
//
// state | meaning
// IDLE  | ready for a new transaction; first valid bit is address bit 0
// ADDR  | shifting in remaining address bits
// WDATA | shifting in write data bits
// WRITE | single-cycle memory write (or out-of-range error)
// RREQ  | single-cycle memory read request (or out-of-range error)
// RWAIT | capture memory read data into the return shift register
// RDATA | shifting read data out, one bit per cycle, no stalls
module serial_slave_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_SIZE   = 4096
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  swdata_i,
  input  logic                  smode_i,
  input  logic                  mvalid_i,
  output logic                  srdata_o,
  output logic                  svalid_o,
  output logic                  sready_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_wen_o,
  output logic                  mem_ren_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  oor_err_o
);

  localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, WRITE, RREQ, RWAIT, RDATA
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rsh_q, rsh_d;
  logic                  sready_q, sready_d;
  logic                  svalid_q, svalid_d;
  logic                  wen_q, wen_d;
  logic                  ren_q, ren_d;
  logic                  oor_q, oor_d;
  logic                  in_range_cur, in_range_next;

  assign in_range_cur  = 64'(addr_q) < 64'(MEM_SIZE);
  assign in_range_next = 64'(addr_d) < 64'(MEM_SIZE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rsh_d   = rsh_q;
    case (state_q)
      IDLE: begin
        if (mvalid_i) begin
          addr_d = (addr_q >> 1) | (ADDR_WIDTH'(swdata_i) << (ADDR_WIDTH - 1));
          mode_d = smode_i;
          if (ADDR_WIDTH == 1) begin
            cnt_d   = '0;
            state_d = smode_i ? WDATA : RREQ;
          end else begin
            cnt_d   = CW'(1);
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        if (mvalid_i) begin
          addr_d = (addr_q >> 1) | (ADDR_WIDTH'(swdata_i) << (ADDR_WIDTH - 1));
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            state_d = mode_q ? WDATA : RREQ;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      WDATA: begin
        if (mvalid_i) begin
          wdata_d = (wdata_q >> 1) | (DATA_WIDTH'(swdata_i) << (DATA_WIDTH - 1));
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = WRITE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      WRITE: state_d = IDLE;
      RREQ:  state_d = RWAIT;
      RWAIT: begin
        // Out-of-range reads return zeros rather than whatever is on the bus.
        rsh_d   = in_range_cur ? mem_rdata_i : '0;
        cnt_d   = '0;
        state_d = RDATA;
      end
      RDATA: begin
        rsh_d = rsh_q >> 1;
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    sready_d = (state_d == IDLE);
    svalid_d = (state_d == RDATA);
    wen_d    = (state_d == WRITE) && in_range_next;
    ren_d    = (state_d == RREQ) && in_range_next;
    oor_d    = ((state_d == WRITE) || (state_d == RREQ)) && !in_range_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rsh_q    <= '0;
      sready_q <= 1'b1;
      svalid_q <= 1'b0;
      wen_q    <= 1'b0;
      ren_q    <= 1'b0;
      oor_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rsh_q    <= rsh_d;
      sready_q <= sready_d;
      svalid_q <= svalid_d;
      wen_q    <= wen_d;
      ren_q    <= ren_d;
      oor_q    <= oor_d;
    end
  end

  // The return shift register drains to zero by the end of RDATA, so its
  // LSB is already low whenever svalid is low.
  assign srdata_o    = rsh_q[0];
  assign svalid_o    = svalid_q;
  assign sready_o    = sready_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wen_o   = wen_q;
  assign mem_ren_o   = ren_q;
  assign oor_err_o   = oor_q;

endmodule

// File: tb/tb_serial_slave_port.sv
// Directed bench for serial_slave_port with a 2048-entry memory model;
// table-driven transactions plus reset and back-to-back sequences.
module tb_serial_slave_port;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int MS = 2048;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          swdata_i, smode_i, mvalid_i;
  logic          srdata_o, svalid_o, sready_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_wen_o, mem_ren_o, oor_err_o;
  logic [DW-1:0] mem_rdata_i;

  always #5 clk_i = ~clk_i;

  serial_slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .swdata_i(swdata_i), .smode_i(smode_i),
    .mvalid_i(mvalid_i), .srdata_o(srdata_o), .svalid_o(svalid_o),
    .sready_o(sready_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wen_o(mem_wen_o), .mem_ren_o(mem_ren_o), .mem_rdata_i(mem_rdata_i),
    .oor_err_o(oor_err_o)
  );

  // Memory model: read data is valid only the cycle after mem_ren, junk otherwise.
  logic [DW-1:0] mem [0:MS-1];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  always @(posedge clk_i) begin
    if (mem_wen_o) mem[mem_addr_o[10:0]] <= mem_wdata_o;
    else if (pre_en) mem[pre_addr[10:0]] <= pre_data;
    mem_rdata_i <= mem_ren_o ? mem[mem_addr_o[10:0]] : 8'hEE;
  end

  int pcyc = 0;
  always @(posedge clk_i) pcyc <= pcyc + 1;

  int            wen_total = 0, ren_total = 0, oor_total = 0, sv_total = 0, first_sv = 0;
  logic [AW-1:0] wen_addr = '0;
  logic [DW-1:0] wen_data = '0, rbuf = '0;
  logic          sv_prev = 1'b0;
  always @(negedge clk_i) begin
    if (mem_wen_o) begin
      wen_total++;
      wen_addr = mem_addr_o;
      wen_data = mem_wdata_o;
    end
    if (mem_ren_o) ren_total++;
    if (oor_err_o) oor_total++;
    if (svalid_o) begin
      sv_total++;
      rbuf = {srdata_o, rbuf[7:1]};
      if (!sv_prev) first_sv = pcyc;
    end
    sv_prev = svalid_o;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          pre;
    int            sa_pos, sa_len, sd_pos, sd_len;
    logic          exp_oor;
  } vec_t;

  task automatic drive_bits(input logic [15:0] v, input int n, input logic mode0,
                            input int st_pos, input int st_len, output int last_cyc);
    last_cyc = pcyc;
    for (int i = 0; i < n; i++) begin
      if (i == st_pos) begin
        for (int s = 0; s < st_len; s++) begin
          mvalid_i = 1'b0;
          swdata_i = 1'($urandom);
          smode_i  = 1'($urandom);
          @(negedge clk_i);
        end
      end
      mvalid_i = 1'b1;
      swdata_i = v[i];
      smode_i  = (i == 0) ? mode0 : 1'($urandom);
      last_cyc = pcyc;
      @(negedge clk_i);
    end
  endtask

  task automatic wait_ready(input string tag);
    int g;
    g = 0;
    while (!sready_o && g < 200) begin
      @(negedge clk_i);
      g++;
    end
    chk({tag, " sready_timeout"}, 32'(sready_o), 32'd1);
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int   s_wen, s_ren, s_oor, s_sv, t0, last_a, last_d, dur, exp_dur;
    logic inr;
    inr = !v.exp_oor;
    wait_ready({tag, " start"});
    if (v.pre) begin
      pre_addr = v.addr;
      pre_data = v.data;
      pre_en   = 1'b1;
      @(negedge clk_i);
      pre_en = 1'b0;
    end
    s_wen = wen_total; s_ren = ren_total; s_oor = oor_total; s_sv = sv_total;
    t0 = pcyc;
    drive_bits(16'(v.addr), AW, v.wr, v.sa_pos, v.sa_len, last_a);
    if (v.wr) drive_bits(16'(v.data), DW, 1'b0, v.sd_pos, v.sd_len, last_d);
    mvalid_i = 1'b0;
    wait_ready({tag, " end"});
    dur = pcyc - t0;
    @(negedge clk_i);
    exp_dur = v.wr ? (21 + v.sa_len + v.sd_len) : (22 + v.sa_len);
    chk({tag, " duration"}, 32'(dur), 32'(exp_dur));
    chk({tag, " wen_count"}, 32'(wen_total - s_wen), 32'(v.wr && inr));
    if (v.wr && inr) begin
      chk({tag, " wen_addr"}, 32'(wen_addr), 32'(v.addr));
      chk({tag, " wen_data"}, 32'(wen_data), 32'(v.data));
    end
    chk({tag, " ren_count"}, 32'(ren_total - s_ren), 32'(!v.wr && inr));
    chk({tag, " oor_count"}, 32'(oor_total - s_oor), 32'(v.exp_oor));
    chk({tag, " svalid_count"}, 32'(sv_total - s_sv), v.wr ? 32'd0 : 32'd8);
    if (!v.wr) begin
      chk({tag, " rdata"}, 32'(rbuf), 32'(v.data));
      chk({tag, " read_latency"}, 32'(first_sv - last_a), 32'd3);
    end
  endtask

  vec_t tbl [12];

  initial begin
    int   s_wen, s_ren, s_oor, s_sv, t0, dummy, dur;
    vec_t v;

    tbl[0]  = '{1'b0, 12'h123, 8'h3C, 1'b1, -1, 0, -1, 0, 1'b0};
    tbl[1]  = '{1'b1, 12'h123, 8'hA5, 1'b0, -1, 0, -1, 0, 1'b0};
    tbl[2]  = '{1'b1, 12'h123, 8'hA5, 1'b0,  5, 3,  3, 2, 1'b0};
    tbl[3]  = '{1'b0, 12'h123, 8'hA5, 1'b0, -1, 0, -1, 0, 1'b0};
    tbl[4]  = '{1'b1, 12'h900, 8'h77, 1'b0, -1, 0, -1, 0, 1'b1};
    tbl[5]  = '{1'b0, 12'h900, 8'h00, 1'b0, -1, 0, -1, 0, 1'b1};
    tbl[6]  = '{1'b1, 12'h7FF, 8'h81, 1'b0, -1, 0, -1, 0, 1'b0};
    tbl[7]  = '{1'b0, 12'h7FF, 8'h81, 1'b0, -1, 0, -1, 0, 1'b0};
    tbl[8]  = '{1'b1, 12'h800, 8'h42, 1'b0, -1, 0, -1, 0, 1'b1};
    tbl[9]  = '{1'b0, 12'h123, 8'hA5, 1'b0, 11, 4, -1, 0, 1'b0};
    tbl[10] = '{1'b1, 12'h000, 8'h5E, 1'b0, -1, 0, -1, 0, 1'b0};
    tbl[11] = '{1'b0, 12'h000, 8'h5E, 1'b0, -1, 0, -1, 0, 1'b0};

    rst_i = 1'b1; mvalid_i = 1'b0; swdata_i = 1'b0; smode_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("reset sready", 32'(sready_o), 32'd1);
    chk("reset svalid", 32'(svalid_o), 32'd0);
    chk("reset srdata", 32'(srdata_o), 32'd0);
    chk("reset mem_wen", 32'(mem_wen_o), 32'd0);
    chk("reset mem_ren", 32'(mem_ren_o), 32'd0);
    chk("reset oor_err", 32'(oor_err_o), 32'd0);
    chk("reset mem_addr", 32'(mem_addr_o), 32'd0);
    chk("reset mem_wdata", 32'(mem_wdata_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int r = 0; r < 12; r++) run_txn(tbl[r], $sformatf("row%0d", r));

    // Reset after five address bits of a write.
    wait_ready("midrst start");
    s_wen = wen_total; s_ren = ren_total; s_oor = oor_total; s_sv = sv_total;
    drive_bits(16'h0AA, 5, 1'b1, -1, 0, dummy);
    mvalid_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("midrst sready", 32'(sready_o), 32'd1);
    chk("midrst mem_addr", 32'(mem_addr_o), 32'd0);
    repeat (30) @(negedge clk_i);
    chk("midrst wen_count", 32'(wen_total - s_wen), 32'd0);
    chk("midrst ren_count", 32'(ren_total - s_ren), 32'd0);
    chk("midrst oor_count", 32'(oor_total - s_oor), 32'd0);
    chk("midrst svalid_count", 32'(sv_total - s_sv), 32'd0);
    v = '{1'b1, 12'h001, 8'hFF, 1'b0, -1, 0, -1, 0, 1'b0};
    run_txn(v, "postrst_wr");
    v = '{1'b0, 12'h001, 8'hFF, 1'b0, -1, 0, -1, 0, 1'b0};
    run_txn(v, "postrst_rd");

    // Back-to-back write then read; input toggling during WRITE must be ignored.
    wait_ready("b2b start");
    s_wen = wen_total; s_ren = ren_total; s_oor = oor_total; s_sv = sv_total;
    t0 = pcyc;
    drive_bits(16'h0AB, AW, 1'b1, -1, 0, dummy);
    drive_bits(16'h0C3, DW, 1'b0, -1, 0, dummy);
    mvalid_i = 1'b1; swdata_i = 1'b1; smode_i = 1'b1;
    @(negedge clk_i);
    drive_bits(16'h0AB, AW, 1'b0, -1, 0, dummy);
    mvalid_i = 1'b0;
    wait_ready("b2b end");
    dur = pcyc - t0;
    @(negedge clk_i);
    chk("b2b duration", 32'(dur), 32'd43);
    chk("b2b wen_count", 32'(wen_total - s_wen), 32'd1);
    chk("b2b wen_addr", 32'(wen_addr), 32'h0AB);
    chk("b2b wen_data", 32'(wen_data), 32'hC3);
    chk("b2b ren_count", 32'(ren_total - s_ren), 32'd1);
    chk("b2b oor_count", 32'(oor_total - s_oor), 32'd0);
    chk("b2b svalid_count", 32'(sv_total - s_sv), 32'd8);
    chk("b2b rdata", 32'(rbuf), 32'hC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_slave_port.md
SERIAL_SLAVE_PORT -- requirements
Module: serial_slave_port

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: slave-local address bits received serially.
REQ-002 Parameter DATA_WIDTH, default 8: data word bits.
REQ-003 Parameter MEM_SIZE, default 4096: number of valid memory locations; addresses >= MEM_SIZE are out of range.
REQ-004 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 swdata  input  1  serial address/write-data bit from bus, LSB first.
REQ-008 smode  input  1  0 = read, 1 = write; sampled with first address bit.
REQ-009 mvalid  input  1  swdata bit valid this cycle.
REQ-010 srdata  output  1  serial read-data bit to bus, LSB first.
REQ-011 svalid  output  1  srdata bit valid this cycle.
REQ-012 sready  output  1  port idle and able to accept a new transaction.
REQ-013 mem_addr  output  ADDR_WIDTH  memory address, held from end of address phase until IDLE.
REQ-014 mem_wdata  output  DATA_WIDTH  memory write data.
REQ-015 mem_wen  output  1  one-cycle memory write strobe.
REQ-016 mem_ren  output  1  one-cycle memory read strobe.
REQ-017 mem_rdata  input  DATA_WIDTH  memory read data, valid exactly one cycle after mem_ren.
REQ-018 oor_err  output  1  one-cycle pulse when an out-of-range transaction completes.

Function
REQ-019 States SHALL be IDLE, ADDR, WDATA, WRITE, RREQ, RWAIT, RDATA; all outputs registered.
REQ-020 sready SHALL be 1 only in IDLE.
REQ-021 IDLE: mvalid=1 -> capture swdata as address bit 0, latch smode, bit counter=1, go ADDR (ADDR_WIDTH=1: go straight to phase end per REQ-022).
REQ-022 ADDR: each mvalid=1 cycle shifts next address bit in; mvalid=0 cycles stall, no count; after bit ADDR_WIDTH-1 -> WDATA if latched mode=1, else RREQ; counter cleared.
REQ-023 WDATA: DATA_WIDTH mvalid-qualified bits, LSB first, stalls as in ADDR; after last bit -> WRITE.
REQ-024 WRITE (one cycle): mem_wen=1 with mem_addr/mem_wdata stable if address < MEM_SIZE, else mem_wen=0 and oor_err=1; -> IDLE.
REQ-025 RREQ (one cycle): mem_ren=1 if in range, else oor_err=1; -> RWAIT.
REQ-026 RWAIT (one cycle): load mem_rdata into shift register (all zeros if out of range); -> RDATA.
REQ-027 RDATA: exactly DATA_WIDTH consecutive cycles of svalid=1, srdata = bit 0,1,...; no stalls; after last bit -> IDLE.
REQ-028 Read latency: first svalid 3 cycles after the edge sampling the last address bit.
REQ-029 mvalid, swdata, smode SHALL be ignored in WRITE, RREQ, RWAIT, RDATA; smode changes after bit 0 ignored.
REQ-030 Back-to-back: mvalid=1 on the first IDLE cycle after WRITE/RDATA SHALL start a new transaction.
REQ-031 svalid, mem_wen, mem_ren, oor_err SHALL never assert outside their stated states.

Reset
REQ-032 rst=1 at a rising edge SHALL force IDLE, clear counters and shift registers, from any state including mid-transfer.
REQ-033 Reset values: sready=1, svalid=0, srdata=0, mem_wen=0, mem_ren=0, oor_err=0, mem_addr=0, mem_wdata=0.
REQ-034 Reset mid-transfer SHALL issue no mem_wen/mem_ren/svalid afterwards; partial bits discarded.

Verification
REQ-035 Write addr 0x123 data 0xA5, mvalid continuous -> single mem_wen cycle with mem_addr=0x123, mem_wdata=0xA5; sready low 21 cycles, then 1.
REQ-036 Read addr 0x123, mem_rdata=0x3C one cycle after mem_ren -> svalid high 8 cycles, srdata 0,0,1,1,1,1,0,0; first svalid 3 cycles after last address bit.
REQ-037 Write with mvalid low 3 cycles mid-address and 2 cycles mid-data -> same memory write as REQ-035, delayed 5 cycles; no extra strobes.
REQ-038 MEM_SIZE=2048, write to 0x900 -> no mem_wen, oor_err pulse 1 cycle; read 0x900 -> no mem_ren, 8 svalid bits all 0, oor_err 1 cycle.
REQ-039 rst asserted after 5 address bits -> sready=1 next cycle, no strobes; fresh write to 0x001 data 0xFF then completes correctly.
REQ-040 Back-to-back write then read of same address, mvalid asserted first IDLE cycle -> both complete; read returns written value from memory model.
